// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath width, ALU and RV32M op codes, EX/MD FSM state encoding
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction
endpackage

// File: rtl/alu.sv
// alu: integer ALU
//   a, b : operands; ctrl : ALU op code; y : result
module alu
    import riscv_pkg::*;
#(
    parameter int BIT_W = XLEN
) (
    input  logic [BIT_W-1:0] a,
    input  logic [BIT_W-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [BIT_W-1:0] y
);
    logic [$clog2(BIT_W)-1:0] w_sh;
    assign w_sh = b[$clog2(BIT_W)-1:0];
    always_comb begin
        y = '0;
        case (ctrl)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << w_sh;
            ALU_SRL:  y = a >> w_sh;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = BIT_W'($signed(a) < $signed(b));
            ALU_SRA:  y = $signed(a) >>> w_sh;
            ALU_SLTU: y = BIT_W'(a < b);
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/md_div_iter.sv
// md_div_iter: radix-2 restoring divider, one quotient bit per cycle
//   start_i loads operands; done_o marks the cycle whose edge retires the last bit;
//   quo_o/rem_o are sign-fixed results, stable once done_o has passed
module md_div_iter
    import riscv_pkg::*;
#(
    parameter int BIT_W = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [BIT_W-1:0] dividend_i,
    input  logic [BIT_W-1:0] divisor_i,
    output logic             done_o,
    output logic [BIT_W-1:0] quo_o,
    output logic [BIT_W-1:0] rem_o
);
    localparam int CW = $clog2(BIT_W + 1);
    logic [CW-1:0]    r_cnt;
    logic [BIT_W-1:0] r_quo, r_rem, r_dvs;
    logic             r_neg_q, r_neg_r;
    logic             w_sa, w_sb;
    logic [BIT_W:0]   w_shift, w_sub;
    assign w_sa    = signed_i & dividend_i[BIT_W-1];
    assign w_sb    = signed_i & divisor_i[BIT_W-1];
    assign w_shift = {r_rem, r_quo[BIT_W-1]};
    assign w_sub   = w_shift - {1'b0, r_dvs};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (start_i) begin
            r_quo   <= w_sa ? -dividend_i : dividend_i;
            r_dvs   <= w_sb ? -divisor_i : divisor_i;
            r_rem   <= '0;
            r_cnt   <= CW'(BIT_W);
            // a zero divisor must yield all-ones, so never negate that quotient
            r_neg_q <= (w_sa ^ w_sb) & (|divisor_i);
            r_neg_r <= w_sa;
        end else if (r_cnt != '0) begin
            r_rem <= w_sub[BIT_W] ? w_shift[BIT_W-1:0] : w_sub[BIT_W-1:0];
            r_quo <= {r_quo[BIT_W-2:0], ~w_sub[BIT_W]};
            r_cnt <= r_cnt - CW'(1);
        end
    end
    assign done_o = (r_cnt == CW'(1));
    assign quo_o  = r_neg_q ? -r_quo : r_quo;
    assign rem_o  = r_neg_r ? -r_rem : r_rem;
endmodule

// File: rtl/ex_md_stage.sv
// ex_md_stage: EX stage with ALU, branch redirect and multi-cycle RV32M unit
//   in : valid_i, pc_i/rs1_i/rs2_i/imm_i, alusrc_i, aluctrl_i, md_en_i, md_op_i,
//        branch_i/bne_i/jalr_i, rd_i, ctrl_i, stall_i
//   out: busy_o, registered valid_o/result_o/wdata_o/rd_o/ctrl_o,
//        combinational make_correction_o/pc_correction_o
module ex_md_stage
    import riscv_pkg::*;
#(
    parameter int BIT_W  = XLEN,
    parameter int DIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [BIT_W-1:0] pc_i,
    input  logic [BIT_W-1:0] rs1_i,
    input  logic [BIT_W-1:0] rs2_i,
    input  logic [BIT_W-1:0] imm_i,
    input  logic             alusrc_i,
    input  logic [3:0]       aluctrl_i,
    input  logic             md_en_i,
    input  logic [2:0]       md_op_i,
    input  logic             branch_i,
    input  logic             bne_i,
    input  logic             jalr_i,
    input  logic [4:0]       rd_i,
    input  logic [3:0]       ctrl_i,
    input  logic             stall_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [BIT_W-1:0] result_o,
    output logic [BIT_W-1:0] wdata_o,
    output logic [4:0]       rd_o,
    output logic [3:0]       ctrl_o,
    output logic             make_correction_o,
    output logic [BIT_W-1:0] pc_correction_o
);
    logic [1:0]         r_state;
    logic [BIT_W-1:0]   r_md_a, r_md_b, r_md_res, r_result, r_wdata;
    logic [2:0]         r_op;
    logic [4:0]         r_md_rd, r_rd;
    logic [3:0]         r_md_ctrl, r_ctrl;
    logic               r_valid;
    logic [BIT_W-1:0]   w_opa, w_opb, w_alu, w_quo, w_rem, w_mul_res, w_md_res;
    logic [2*BIT_W-1:0] w_prod;
    logic               w_accept, w_div_done, w_calc_done, w_ma_s, w_mb_s;
    assign w_opa = branch_i ? pc_i : rs1_i;
    assign w_opb = alusrc_i ? imm_i : rs2_i;
    alu #(.BIT_W(BIT_W)) u_alu (.a(w_opa), .b(w_opb), .ctrl(aluctrl_i), .y(w_alu));
    assign busy_o            = (r_state != ST_IDLE);
    assign w_accept          = (r_state == ST_IDLE) & valid_i & md_en_i & ~stall_i;
    assign make_correction_o = valid_i & ~busy_o & (jalr_i | (branch_i & ((rs1_i == rs2_i) ^ bne_i)));
    assign pc_correction_o   = w_alu;
    // sign-extend to 2*BIT_W so one unsigned multiply covers all four signedness mixes
    assign w_ma_s    = ((r_op == MD_MULH) | (r_op == MD_MULHSU)) & r_md_a[BIT_W-1];
    assign w_mb_s    = (r_op == MD_MULH) & r_md_b[BIT_W-1];
    assign w_prod    = {{BIT_W{w_ma_s}}, r_md_a} * {{BIT_W{w_mb_s}}, r_md_b};
    assign w_mul_res = (r_op == MD_MUL) ? w_prod[BIT_W-1:0] : w_prod[2*BIT_W-1:BIT_W];
    generate
        if (DIV_EN != 0) begin : g_div
            md_div_iter #(.BIT_W(BIT_W)) u_div (
                .clk       (clk),
                .rst_n     (rst_n),
                .start_i   (w_accept & is_div_op(md_op_i)),
                .signed_i  (~md_op_i[0]),
                .dividend_i(rs1_i),
                .divisor_i (rs2_i),
                .done_o    (w_div_done),
                .quo_o     (w_quo),
                .rem_o     (w_rem)
            );
        end else begin : g_nodiv
            assign w_div_done = 1'b0;
            assign w_quo      = '0;
            assign w_rem      = '0;
        end
    endgenerate
    assign w_calc_done = ~is_div_op(r_op) | (DIV_EN == 0) | w_div_done;
    assign w_md_res    = (is_div_op(r_op) & (DIV_EN != 0)) ? (r_op[1] ? w_rem : w_quo) : r_md_res;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_ctrl    <= '0;
            r_md_a    <= '0;
            r_md_b    <= '0;
            r_md_res  <= '0;
            r_op      <= '0;
            r_md_rd   <= '0;
            r_md_ctrl <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // an accepted MD op leaves a bubble until DONE writes its result
                    if (!stall_i) begin
                        r_valid  <= valid_i & ~md_en_i;
                        r_ctrl   <= (valid_i & ~md_en_i) ? ctrl_i : 4'b0;
                        r_result <= w_alu;
                        r_wdata  <= rs2_i;
                        r_rd     <= rd_i;
                    end
                    if (w_accept) begin
                        r_state   <= ST_CALC;
                        r_md_a    <= rs1_i;
                        r_md_b    <= rs2_i;
                        r_op      <= md_op_i;
                        r_md_rd   <= rd_i;
                        r_md_ctrl <= ctrl_i;
                    end
                end
                ST_CALC: begin
                    r_md_res <= is_div_op(r_op) ? '0 : w_mul_res;
                    if (w_calc_done) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!stall_i) begin
                        r_state  <= ST_IDLE;
                        r_valid  <= 1'b1;
                        r_result <= w_md_res;
                        r_wdata  <= r_md_b;
                        r_rd     <= r_md_rd;
                        r_ctrl   <= r_md_ctrl;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign wdata_o  = r_wdata;
    assign rd_o     = r_rd;
    assign ctrl_o   = r_ctrl;
endmodule

// File: tb/tb_ex_md_stage.sv
// tb_ex_md_stage: directed-vector self-checking bench for ex_md_stage
module tb_ex_md_stage;
    import riscv_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0, alusrc_i = 1'b0, md_en_i = 1'b0;
    logic        branch_i = 1'b0, bne_i = 1'b0, jalr_i = 1'b0, stall_i = 1'b0;
    logic [31:0] pc_i = '0, rs1_i = '0, rs2_i = '0, imm_i = '0;
    logic [3:0]  aluctrl_i = '0, ctrl_i = '0;
    logic [2:0]  md_op_i = '0;
    logic [4:0]  rd_i = '0;
    logic        busy_o, valid_o, make_correction_o;
    logic [31:0] result_o, wdata_o, pc_correction_o;
    logic [4:0]  rd_o;
    logic [3:0]  ctrl_o;
    int          n_vec = 0, n_err = 0;
    ex_md_stage #(.BIT_W(32), .DIV_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pc_i(pc_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .imm_i(imm_i), .alusrc_i(alusrc_i), .aluctrl_i(aluctrl_i),
        .md_en_i(md_en_i), .md_op_i(md_op_i), .branch_i(branch_i), .bne_i(bne_i),
        .jalr_i(jalr_i), .rd_i(rd_i), .ctrl_i(ctrl_i), .stall_i(stall_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .wdata_o(wdata_o),
        .rd_o(rd_o), .ctrl_o(ctrl_o), .make_correction_o(make_correction_o),
        .pc_correction_o(pc_correction_o)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic idle();
        valid_i = 1'b0; md_en_i = 1'b0; branch_i = 1'b0; bne_i = 1'b0;
        jalr_i = 1'b0; alusrc_i = 1'b0; ctrl_i = '0; rd_i = '0;
    endtask
    task automatic set_op(input logic md, input logic [2:0] op, input logic [3:0] aluc,
                          input logic [31:0] a, input logic [31:0] b);
        idle();
        valid_i = 1'b1; md_en_i = md; md_op_i = op; aluctrl_i = aluc;
        rs1_i = a; rs2_i = b; rd_i = 5'd5; ctrl_i = 4'b0001;
    endtask
    task automatic alu_run(input string tag, input logic [3:0] aluc,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_op(1'b0, 3'd0, aluc, a, b);
        step();
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        idle();
    endtask
    task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        set_op(1'b1, op, ALU_ADD, a, b);
        step();
        idle();
        repeat (lat - 1) step();
        chk({tag, "_busy_pre"}, 32'(busy_o), 32'd1);
        chk({tag, "_valid_pre"}, 32'(valid_o), 32'd0);
        step();
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_wdata"}, wdata_o, b);
    endtask
    initial begin
        repeat (2) step();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_ctrl", 32'(ctrl_o), 32'd0);
        rst_n = 1'b1;
        alu_run("add", ALU_ADD, 32'd5, 32'd7, 32'd12);
        chk("add_rd", 32'(rd_o), 32'd5);
        chk("add_ctrl", 32'(ctrl_o), 32'd1);
        set_op(1'b0, 3'd0, ALU_ADD, 32'd1, 32'd1);
        stall_i = 1'b1;
        step();
        chk("stall_idle_hold", result_o, 32'd12);
        chk("stall_idle_valid", 32'(valid_o), 32'd1);
        stall_i = 1'b0;
        idle();
        step();
        chk("bubble_valid", 32'(valid_o), 32'd0);
        chk("bubble_ctrl", 32'(ctrl_o), 32'd0);
        alu_run("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_run("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        set_op(1'b0, 3'd0, ALU_ADD, 32'd10, 32'd0);
        alusrc_i = 1'b1; imm_i = 32'h20;
        step();
        chk("addi", result_o, 32'h2A);
        set_op(1'b0, 3'd0, ALU_ADD, 32'd3, 32'd3);
        branch_i = 1'b1; alusrc_i = 1'b1; pc_i = 32'h100; imm_i = 32'd8;
        #1;
        chk("beq_mc", 32'(make_correction_o), 32'd1);
        chk("beq_pc", pc_correction_o, 32'h108);
        bne_i = 1'b1;
        #1;
        chk("bne_mc", 32'(make_correction_o), 32'd0);
        set_op(1'b0, 3'd0, ALU_ADD, 32'h200, 32'd0);
        jalr_i = 1'b1; alusrc_i = 1'b1; imm_i = 32'd4;
        #1;
        chk("jalr_mc", 32'(make_correction_o), 32'd1);
        chk("jalr_pc", pc_correction_o, 32'h204);
        valid_i = 1'b0;
        #1;
        chk("jalr_nv_mc", 32'(make_correction_o), 32'd0);
        idle();
        step();
        md_run("mulh", MD_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 2);
        md_run("mul", MD_MUL, 32'd6, 32'd7, 32'd42, 2);
        md_run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        md_run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        md_run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        md_run("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        md_run("divu_z", MD_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 33);
        md_run("remu_z", MD_REMU, 32'd9, 32'd0, 32'd9, 33);
        md_run("div_z_neg", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33);
        md_run("rem_z_neg", MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33);
        md_run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        md_run("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        md_run("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
        md_run("remu", MD_REMU, 32'd100, 32'd7, 32'd2, 33);
        set_op(1'b1, MD_MUL, ALU_ADD, 32'd6, 32'd7);
        step();
        idle();
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_stall_busy", 32'(busy_o), 32'd1);
            chk("done_stall_valid", 32'(valid_o), 32'd0);
        end
        stall_i = 1'b0;
        step();
        chk("done_rel_res", result_o, 32'd42);
        chk("done_rel_valid", 32'(valid_o), 32'd1);
        chk("done_rel_busy", 32'(busy_o), 32'd0);
        set_op(1'b1, MD_DIV, ALU_ADD, 32'd1000, 32'd3);
        step();
        idle();
        repeat (9) step();
        rst_n = 1'b0;
        step();
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        rst_n = 1'b1;
        alu_run("post_rst_add", ALU_ADD, 32'd1, 32'd2, 32'd3);
        repeat (30) step();
        chk("post_rst_idle", 32'(busy_o), 32'd0);
        chk("post_rst_novalid", 32'(valid_o), 32'd0);
        md_run("post_rst_divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_md_stage.md
EX_MD_STAGE -- requirements
Module: ex_md_stage

Interface
REQ-001 SHALL have parameter BIT_W, default 32, datapath width.
REQ-002 SHALL have parameter DIV_EN, default 1; when 0, div/rem ops SHALL produce 0 after one cycle.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port valid_i, input, 1, ID/EX slot holds a live instruction.
REQ-006 SHALL have port pc_i, rs1_i, rs2_i, imm_i, input, BIT_W each, PC and already-forwarded operands.
REQ-007 SHALL have port alusrc_i, input, 1, operand B = imm_i when 1.
REQ-008 SHALL have port aluctrl_i, input, 4, ALU op code (existing alu encoding).
REQ-009 SHALL have port md_en_i, input, 1, instruction is RV32M; md_op_i, input, 3, funct3 (MUL..REMU).
REQ-010 SHALL have port branch_i, bne_i, jalr_i, input, 1 each, control-flow class.
REQ-011 SHALL have port rd_i, input, 5; ctrl_i, input, 4, {memrd,memwr,mem2reg,regwr}, passed through.
REQ-012 SHALL have port stall_i, input, 1, downstream hold of EX/MEM register.
REQ-013 SHALL have port busy_o, output, 1, stall IF/ID/EX upstream.
REQ-014 SHALL have port valid_o, output, 1; result_o, wdata_o, output, BIT_W; rd_o, output, 5; ctrl_o, output, 4.
REQ-015 SHALL have port make_correction_o, output, 1; pc_correction_o, output, BIT_W, combinational redirect.

Function
REQ-016 Non-MD ops SHALL register ALU result one cycle after acceptance; opA = pc_i for branch, else rs1_i.
REQ-017 FSM states IDLE, CALC, DONE; an MD op accepted in IDLE (valid_i & md_en_i & !stall_i) SHALL enter CALC.
REQ-018 busy_o SHALL be 1 in CALC and DONE, 0 in IDLE; upstream inputs SHALL be ignored while busy_o=1.
REQ-019 MUL/MULH/MULHSU/MULHU SHALL spend one CALC cycle (2*BIT_W product, signedness per funct3); valid_o rises 2 cycles after accept.
REQ-020 DIV/DIVU/REM/REMU SHALL use radix-2 restoring division, one bit per cycle, BIT_W CALC cycles; valid_o rises BIT_W+1 cycles after accept.
REQ-021 Signed div SHALL operate on magnitudes and fix sign: quotient negative iff signs differ, remainder takes dividend sign.
REQ-022 Divide by zero SHALL return quotient all-ones, remainder = dividend, no extra cycles.
REQ-023 Overflow (-2^(BIT_W-1) / -1) SHALL return quotient = dividend, remainder 0.
REQ-024 DONE SHALL load output registers and return to IDLE; if stall_i=1 in DONE, SHALL stay in DONE.
REQ-025 stall_i=1 SHALL hold all output registers unchanged in every state.
REQ-026 make_correction_o SHALL = jalr_i | (branch_i & ((rs1_i==rs2_i)^bne_i)), gated by valid_i & !busy_o; pc_correction_o = ALU output.
REQ-027 Bubbles (valid_i=0) SHALL register valid_o=0 and ctrl_o=0.

Reset
REQ-028 rst_n=0 at a clock edge SHALL zero all output registers, force IDLE, busy_o=0, abort any in-flight division.

Structure
REQ-029 md_op encodings, FSM state encoding and BIT_W default SHALL reside in shared package riscv_pkg.
REQ-030 Divider datapath SHALL be sub-module md_div_iter (start/done handshake); existing alu SHALL be reused.

Verification
REQ-031 ADD rs1=5, rs2=7 -> result_o=12, valid_o next cycle, busy_o never 1.
REQ-032 MULH rs1=0x80000000, rs2=2 -> result_o=0xFFFFFFFF at cycle 2, busy_o 1 for 2 cycles.
REQ-033 DIV rs1=-7, rs2=2 -> result_o=0xFFFFFFFD at cycle 33; REM same operands -> 0xFFFFFFFF.
REQ-034 DIVU rs1=9, rs2=0 -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 stall_i=1 during DONE for 3 cycles -> outputs held, FSM in DONE, released one cycle after stall_i falls.
REQ-036 rst_n=0 at cycle 10 of a DIV -> next cycle busy_o=0, valid_o=0, new ADD accepted and completes normally.
